fifo_readout: RTL

- Read-side controller for the dual-channel sample storage block. Runs on the storage read clock.
- On a host start command it drives rdenA/rdenB to pull a programmed number of 16-bit words from the storage output register.
- It compensates for the fixed FIFO plus output-register read latency and presents the words on a valid/ready stream toward the host interface (USB/parallel bridge).
- A small skid buffer absorbs host backpressure, so no word already in flight is lost.

---
 rtl/storage_pkg.sv | 23 ++
 rtl/readout_skid_fifo.sv | 56 +++++
 rtl/fifo_readout.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/storage_pkg.sv
// Shared definitions for the dual-channel sample storage block and its readout.
// Holds the readout FSM encoding, channel-select codes and the storage read latency.
package storage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_e;

    localparam logic [1:0] CH_NONE = 2'b00;
    localparam logic [1:0] CH_A    = 2'b01;
    localparam logic [1:0] CH_B    = 2'b10;
    localparam logic [1:0] CH_AB   = 2'b11;

    // FIFO read plus storage output register.
    localparam int RD_LATENCY_DEF = 2;

    // Skid entry: {chan, data}.
    localparam int SKID_W = 17;

endpackage

// File: rtl/readout_skid_fifo.sv
// Synchronous FIFO of DEPTH entries holding {chan, data}; head is always visible on dout_o.
// Zero-latency head, one-cycle push-to-visible; caller must never push when full or pop when empty.
// Simultaneous push and pop leave the count unchanged.
module readout_skid_fifo
    import storage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [SKID_W-1:0] din_i,
    input  logic              pop_i,
    output logic [SKID_W-1:0] dout_o,
    output logic [CW-1:0]     count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SKID_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fifo_readout.sv
// Read-side controller: issues rdenA/rdenB for a programmed word count and streams words out.
// First tx_valid RD_LATENCY+1 cycles after start; one word per cycle without backpressure.
// Reads are credit-limited so the skid FIFO absorbs every in-flight word while tx_ready is low.
module fifo_readout
    import storage_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             rdclk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       chan_sel,
    input  logic [CNT_W-1:0] num_words,
    input  logic [15:0]      din,
    output logic             rdenA,
    output logic             rdenB,
    output logic [15:0]      tx_data,
    output logic             tx_chan,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             done
);

    localparam int SCW = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    rd_state_e              state_q;
    logic [CNT_W-1:0]       num_q, issued_q, acc_q;
    logic [CNT_W-1:0]       issued_d, acc_d;
    logic [1:0]             mode_q;
    logic                   chan_q;
    logic                   busy_q, done_q;
    logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_chan_q;

    logic [SCW-1:0]         skid_cnt;
    logic [SKID_W-1:0]      skid_head;
    logic [7:0]             out_cnt;
    logic                   credit_ok, issue, push, pop;

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            out_cnt = out_cnt + {7'd0, pipe_vld_q[i]};
        end
    end

    // rden is decoded from registered state only, so a read can issue in the first ISSUE cycle.
    assign credit_ok = (out_cnt + 8'(skid_cnt)) < 8'(SKID_DEPTH);
    assign issue     = (state_q == ST_ISSUE) && credit_ok;
    assign rdenA     = issue && !chan_q;
    assign rdenB     = issue && chan_q;

    assign push      = pipe_vld_q[RD_LATENCY-1];
    assign tx_valid  = (skid_cnt != '0);
    assign pop       = tx_valid && tx_ready;
    assign tx_chan   = skid_head[16];
    assign tx_data   = skid_head[15:0];
    assign issued_d  = issued_q + ONE;
    assign acc_d     = acc_q + ONE;
    assign tx_last   = tx_valid && (acc_d == num_q);
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge rdclk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q  <= '0;
            pipe_chan_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_chan_q[0] <= chan_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_chan_q[i] <= pipe_chan_q[i-1];
            end
        end
    end

    always_ff @(posedge rdclk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            issued_q <= '0;
            acc_q    <= '0;
            mode_q   <= CH_NONE;
            chan_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (chan_sel != CH_NONE && num_words != '0) begin
                            num_q    <= num_words;
                            mode_q   <= chan_sel;
                            chan_q   <= (chan_sel == CH_B);
                            issued_q <= '0;
                            acc_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_ISSUE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (pop) begin
                        acc_q <= acc_d;
                    end
                    if (issue) begin
                        issued_q <= issued_d;
                        if (mode_q == CH_AB) begin
                            chan_q <= !chan_q;
                        end
                        if (issued_d == num_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop) begin
                        acc_q <= acc_d;
                        if (tx_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    readout_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .CW    (SCW)
    ) u_skid (
        .clk_i   (rdclk),
        .rst_ni  (rst),
        .push_i  (push),
        .din_i   ({pipe_chan_q[RD_LATENCY-1], din}),
        .pop_i   (pop),
        .dout_o  (skid_head),
        .count_o (skid_cnt)
    );

endmodule
